qeciphy_crc8_checker: RTL

- Receive-side companion to the CRC-8/SMBUS generator.
- Accepts a byte stream framed as N payload bytes plus one trailing CRC byte (tlast on the CRC byte).
- Forwards the payload with the CRC byte stripped and tlast moved to the last payload byte.
- Reports per-frame CRC/length status and keeps a saturating error counter. Sits between the RX byte deframer and the link controller.

---
 rtl/qeciphy_crc8_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/qeciphy_crc8_checker.sv
// CRC-8/SMBUS frame checker: strips the CRC byte and moves tlast to the last payload byte.
// Reports per-frame CRC/length status pulses and keeps a saturating error counter.
//
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   s_t*_i              input byte stream (tlast on CRC byte), no backpressure
//   m_t*_o              payload byte stream (tlast on last payload byte)
//   frame_done_o        1-cycle pulse when a frame ends (good, bad or length error)
//   crc_ok_o            1-cycle pulse, CRC matched
//   crc_err_o           1-cycle pulse, CRC mismatch
//   len_err_o           1-cycle pulse, runt or oversize frame
//   clear_cnt_i         sync clear of the counters
//   err_cnt_o           saturating crc_err + len_err count
//   good_cnt_o          saturating crc_ok count (QECIPHY_CRC8_CHECKER_STATS_EN only)
module qeciphy_crc8_checker #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [7:0]       s_tdata_i,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  output logic [7:0]       m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
  output logic             frame_done_o,
  output logic             crc_ok_o,
  output logic             crc_err_o,
  output logic             len_err_o,
  input  logic             clear_cnt_i,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef QECIPHY_CRC8_CHECKER_STATS_EN
  ,
  output logic [CNT_W-1:0] good_cnt_o
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    crc_base;
  logic [7:0]    crc_nx;

  logic [7:0] mdata_d;
  logic       mv_d;
  logic       ml_d;
  logic       done_d;
  logic       ok_d;
  logic       err_d;
  logic       len_d;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // First beat of a frame restarts the CRC from 0x00.
  assign crc_base = (state_q == IDLE) ? 8'h00 : crc_q;
  assign crc_nx   = crc8_step(crc_base, s_tdata_i);

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    mdata_d = m_tdata_o;
    mv_d    = 1'b0;
    ml_d    = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    len_d   = 1'b0;
    if (s_tvalid_i) begin
      unique case (state_q)
        IDLE: begin
          crc_d = crc_nx;
          if (s_tlast_i) begin
            done_d = 1'b1;
            len_d  = 1'b1;
          end else begin
            hold_d  = s_tdata_i;
            cnt_d   = CW'(1);
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          crc_d   = crc_nx;
          mv_d    = 1'b1;
          mdata_d = hold_q;
          if (s_tlast_i) begin
            ml_d    = 1'b1;
            done_d  = 1'b1;
            ok_d    = (crc_nx == 8'h00);
            err_d   = (crc_nx != 8'h00);
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q < MAX_C) begin
            hold_d = s_tdata_i;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            // Oversize: close the frame on the held byte, drop the rest.
            ml_d    = 1'b1;
            done_d  = 1'b1;
            len_d   = 1'b1;
            cnt_d   = '0;
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (s_tlast_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      crc_q        <= 8'h00;
      hold_q       <= 8'h00;
      cnt_q        <= '0;
      m_tdata_o    <= 8'h00;
      m_tvalid_o   <= 1'b0;
      m_tlast_o    <= 1'b0;
      frame_done_o <= 1'b0;
      crc_ok_o     <= 1'b0;
      crc_err_o    <= 1'b0;
      len_err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      m_tdata_o    <= mdata_d;
      m_tvalid_o   <= mv_d;
      m_tlast_o    <= ml_d;
      frame_done_o <= done_d;
      crc_ok_o     <= ok_d;
      crc_err_o    <= err_d;
      len_err_o    <= len_d;
    end
  end

  // Counters step together with the registered pulse they count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      err_cnt_o <= '0;
    end else if ((err_d | len_d) && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

`ifdef QECIPHY_CRC8_CHECKER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      good_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      good_cnt_o <= '0;
    end else if (ok_d && (good_cnt_o != '1)) begin
      good_cnt_o <= good_cnt_o + 1'b1;
    end
  end
`endif

endmodule
